corr_seq_ctrl: RTL
==================

Name: corr_seq_ctrl

Overview:
- Sequencer and configuration block for the 3-tap systolic correlation PE chain.
- Holds the programmable tap weights and clears the PE partial-sum registers before each frame, since the PEs have no reset.
- Streams a frame of N samples in via a valid/ready handshake, then flushes TAPS-1 zeros so the full correlation (N+TAPS-1 results) emerges.
- Flags each valid datapath output; sits between the sample source and the PE chain.

Parameters:
- TAPS, 3, number of PEs/weights in the chain (≥2).
- XW, 8, sample and weight width.
- YW, 16, datapath result width.
- LEN_W, 8, frame-length width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a frame when idle.
- frame_len  in  LEN_W  sample count N, sampled on accepted start.
- busy  out  1  high from accepted start through the DONE cycle.
- done  out  1  one-cycle pulse in DONE state.
- s_valid  in  1  input sample valid.
- s_data  in  XW  input sample.
- s_ready  out  1  high only in STREAM.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  2  weight index 0..TAPS-1; index 0 is the oldest tap (first PE).
- cfg_wdata  in  XW  weight value.
- cfg_err  out  1  one-cycle pulse: write rejected.
- dp_en  out  1  clock enable to the PE chain.
- dp_x  out  XW  sample to the PE chain.
- dp_w  out  TAPS*XW  weights, w[i] at bits [i*XW +: XW].
- dp_y  in  YW  PE chain result.
- y_data  out  YW  combinational passthrough of dp_y.
- y_valid  out  1  y_data is a frame result.
- y_last  out  1  with y_valid on the final result.

Behaviour:
- Datapath contract:
  - PE registers update only on cycles with dp_en=1.
  - After an enabled edge, Y = w[2]*x[t] + w[1]*x[t-1] + w[0]*x[t-2].
  - Latency is one enabled cycle.
- Reset values:
  - State IDLE; busy, done, s_ready, cfg_err, dp_en, y_valid, y_last all 0.
  - dp_x=0; weights w[i]=i+2 (2,3,4).
- States: IDLE→CLEAR→STREAM→FLUSH→DONE→IDLE.
- IDLE:
  - dp_en=0.
  - start=1 latches frame_len and goes to CLEAR.
- CLEAR:
  - TAPS-1 cycles; dp_en=1, dp_x=0, no y_valid.
  - Exits to STREAM, or to DONE if N=0.
- STREAM:
  - s_ready=1, dp_x=s_data, dp_en=s_valid.
  - Each handshake increments the sample count and sets y_valid next cycle.
  - Bubbles (s_valid=0) freeze the PE chain and produce no y_valid.
  - After the Nth handshake go to FLUSH.
- FLUSH:
  - TAPS-1 cycles; dp_en=1, dp_x=0.
  - Each cycle sets y_valid next cycle; then go to DONE.
- DONE:
  - One cycle; done=1, busy=1.
  - y_valid and y_last asserted for the last flush result; then IDLE.
- Output count: exactly N+TAPS-1 y_valid pulses per frame; the counter is LEN_W+2 bits, so there is no wrap at N=2^LEN_W-1.
- start while busy is ignored. start coincident with DONE is ignored; it must be re-presented in IDLE.
- Weight writes:
  - Accepted only in IDLE; the new weight is visible on dp_w the next cycle.
  - cfg_we while busy, or cfg_addr≥TAPS, pulses cfg_err the next cycle; weights are unchanged.
- cfg_we and start in the same IDLE cycle: the write lands first; the frame uses the new weight.
- Arithmetic widths belong to the PE chain; the controller does no arithmetic on data.
- rst_n asserted mid-frame: immediate return to reset values; the frame is abandoned with no done.
  - The next frame's CLEAR phase guarantees clean partial sums.

Optional Feature:
- Macro CORR_SEQ_CTRL_VALID_ONLY_EN.
- Defined:
  - Only full-window results are flagged: the first TAPS-1 STREAM outputs have y_valid suppressed.
  - FLUSH is skipped: STREAM goes to DONE after a one-cycle wait for the last result.
  - Exactly max(N-TAPS+1, 0) y_valid pulses per frame; y_last marks the final one, or no y_last when the count is 0.
- Undefined: full-correlation behaviour as above.

Test Plan:
- Reset, default weights, N=3, samples 1,2,3 back-to-back -> y_valid results 4,11,20,13,6; y_last on 6; done in that cycle.
- Same frame with s_valid bubbles of 2 cycles between samples -> identical result sequence, no y_valid during bubbles.
- Write w[0]=1, w[1]=1, w[2]=1 in IDLE, N=2, samples 5,7 -> results 5,12,7.
- cfg_we during STREAM, and cfg_addr=3 in IDLE -> cfg_err pulses, dp_w unchanged; start during busy ignored.
- N=0 -> TAPS-1 CLEAR cycles, done pulse, zero y_valid; rst_n low mid-STREAM -> outputs to reset values, next frame correct.
- With CORR_SEQ_CTRL_VALID_ONLY_EN, N=3, samples 1,2,3 -> single y_valid=20 with y_last; N=2 -> no y_valid, done pulse.

Source files
------------

// File: rtl/corr_seq_ctrl.sv
// corr_seq_ctrl: frame sequencer and tap-weight store for the systolic correlation PE chain.
// Clears the reset-less PE partial sums, streams N samples in, then flushes TAPS-1
// zeros so that the full correlation (N+TAPS-1 results) is flagged on y_valid.
// Optional build macro: CORR_SEQ_CTRL_VALID_ONLY_EN -- flag only full-window results
// and skip the FLUSH phase.
module corr_seq_ctrl #(
    parameter int unsigned TAPS  = 3,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // frame control
    input  logic                 start,
    input  logic [LEN_W-1:0]     frame_len,
    output logic                 busy,
    output logic                 done,
    // sample stream in
    input  logic                 s_valid,
    input  logic [XW-1:0]        s_data,
    output logic                 s_ready,
    // weight configuration
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [XW-1:0]        cfg_wdata,
    output logic                 cfg_err,
    // PE chain interface
    output logic                 dp_en,
    output logic [XW-1:0]        dp_x,
    output logic [TAPS*XW-1:0]   dp_w,
    input  logic [YW-1:0]        dp_y,
    // result stream out
    output logic [YW-1:0]        y_data,
    output logic                 y_valid,
    output logic                 y_last
);

    // Sample/phase counter is two bits wider than the frame length so N+TAPS-1 never wraps.
    localparam int unsigned CNT_W   = LEN_W + 2;
    // Index of the final CLEAR / FLUSH cycle.
    localparam int unsigned PH_LAST = TAPS - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic [TAPS-1:0][XW-1:0]  w_q, w_d;

    logic busy_q,    busy_d;
    logic done_q,    done_d;
    logic s_ready_q, s_ready_d;
    logic cfg_err_q, cfg_err_d;
    logic y_valid_q, y_valid_d;
    logic y_last_q,  y_last_d;

    logic             dp_en_c;
    logic [XW-1:0]    dp_x_c;
    logic             cfg_addr_ok;

    // State, counters, weights and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            cfg_err_q <= 1'b0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                w_q[i] <= XW'(i + 2);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            cfg_err_q <= cfg_err_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
            w_q       <= w_d;
        end
    end

    // Next-state, counter, weight-write and datapath-drive decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        w_d         = w_q;
        cfg_err_d   = 1'b0;
        y_valid_d   = 1'b0;
        y_last_d    = 1'b0;
        dp_en_c     = 1'b0;
        dp_x_c      = '0;
        cfg_addr_ok = (32'(cfg_addr) < TAPS);

        // Weights are only writable while idle; any other write is rejected and flagged.
        if (cfg_we) begin
            if ((state_q == S_IDLE) && cfg_addr_ok) begin
                for (int unsigned i = 0; i < TAPS; i++) begin
                    if (32'(cfg_addr) == i) begin
                        w_d[i] = cfg_wdata;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = CNT_W'(frame_len);
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end

            // Push zeros through the chain so stale partial sums cannot leak into the frame.
            S_CLEAR: begin
                dp_en_c = 1'b1;
                if (cnt_q == CNT_W'(PH_LAST)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? S_DONE : S_STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Bubbles hold the chain frozen; each handshake yields one result a cycle later.
            S_STREAM: begin
                dp_en_c = s_valid;
                dp_x_c  = s_data;
                if (s_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CORR_SEQ_CTRL_VALID_ONLY_EN
                    y_valid_d = (cnt_q >= CNT_W'(TAPS - 1));
`else
                    y_valid_d = 1'b1;
`endif
                    if (cnt_d == len_q) begin
                        cnt_d = '0;
`ifdef CORR_SEQ_CTRL_VALID_ONLY_EN
                        // DONE is the one-cycle wait: the last full-window result lands there.
                        y_last_d = y_valid_d;
                        state_d  = S_DONE;
`else
                        state_d  = S_FLUSH;
`endif
                    end
                end
            end

            // Drain the tail of the correlation with zero samples.
            S_FLUSH: begin
                dp_en_c   = 1'b1;
                y_valid_d = 1'b1;
                if (cnt_q == CNT_W'(PH_LAST)) begin
                    y_last_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Single cycle; a start seen here is deliberately dropped.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        s_ready_d = (state_d == S_STREAM);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_ready = s_ready_q;
    assign cfg_err = cfg_err_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;
    assign dp_w    = w_q;
    assign dp_en   = dp_en_c;
    assign dp_x    = dp_x_c;
    assign y_data  = dp_y;

endmodule
